// File: rtl/ks10_status_monitor.sv
// KS10 status-line monitor: timestamps enabled level changes on the CPU status
// inputs and queues them in a show-ahead FIFO drained by valid/ready.
module ks10_status_monitor #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned TSWIDTH  = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PRESCALE = 50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clken,
  input  logic [CHANNELS-1:0]       statIN,
  input  logic [CHANNELS-1:0]       evtMASK,
  input  logic                      dropCLR,
  input  logic                      evtREADY,
  output logic                      evtVALID,
  output logic [3:0]                evtCHAN,
  output logic                      evtLEVEL,
  output logic [TSWIDTH-1:0]        evtTIME,
  output logic [$clog2(DEPTH):0]    fifoCOUNT,
  output logic [7:0]                dropCOUNT,
  output logic [TSWIDTH-1:0]        timeNOW
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW = 5 + TSWIDTH;

  logic [PW-1:0]      r_presc;
  logic [TSWIDTH-1:0] r_time;
  logic [CHANNELS-1:0] r_last, r_pvld, r_plvl;
  logic [TSWIDTH-1:0] r_ptime [CHANNELS];
  logic [7:0]         r_drop;
  logic [DW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_wp, r_rp;
  logic [AW:0]        r_count;

  logic [CHANNELS-1:0] w_edge, w_drain, w_drop;
  logic                w_sel_any, w_wlvl, w_push, w_pop, w_full;
  logic [3:0]          w_sel;
  logic [TSWIDTH-1:0]  w_wtime;
  logic [4:0]          w_ndrop;
  logic [8:0]          w_dsum;
  logic [DW-1:0]       w_head;

  // Timestamp base
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_time  <= '0;
    end else if (clken) begin
      if (r_presc == PW'(PRESCALE - 1)) begin
        r_presc <= '0;
        r_time  <= r_time + TSWIDTH'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign w_edge   = (statIN ^ r_last) & evtMASK;
  assign evtVALID = (r_count != '0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop    = evtVALID & evtREADY;
  assign w_push   = w_sel_any & (~w_full | w_pop);

  // Descending scan so the lowest-numbered valid entry wins
  always_comb begin
    w_sel_any = 1'b0;
    w_sel     = '0;
    w_wlvl    = 1'b0;
    w_wtime   = '0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (r_pvld[i-1]) begin
        w_sel_any = 1'b1;
        w_sel     = 4'(i - 1);
        w_wlvl    = r_plvl[i-1];
        w_wtime   = r_ptime[i-1];
      end
    end
  end

  always_comb begin
    w_drain = '0;
    w_drop  = '0;
    w_ndrop = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_drain[i] = w_push && (w_sel == 4'(i));
      w_drop[i]  = w_edge[i] & r_pvld[i] & ~w_drain[i];
      w_ndrop    = w_ndrop + 5'(w_drop[i]);
    end
    w_dsum = {1'b0, r_drop} + {4'b0, w_ndrop};
  end

  // An edge on a draining entry re-arms it with fresh time; otherwise it overwrites level only
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= '0;
      r_pvld <= '0;
      r_plvl <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) r_ptime[i] <= '0;
    end else begin
      r_last <= statIN;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (w_edge[i]) begin
          r_pvld[i] <= 1'b1;
          r_plvl[i] <= statIN[i];
          if (!r_pvld[i] || w_drain[i]) r_ptime[i] <= r_time;
        end else if (w_drain[i]) begin
          r_pvld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                r_drop <= '0;
    else if (dropCLR)        r_drop <= '0;
    else if (w_dsum > 9'd255) r_drop <= 8'hFF;
    else                     r_drop <= w_dsum[7:0];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {w_sel, w_wlvl, w_wtime};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Head fields read zero while empty so reset values hold without clearing the array
  assign w_head    = r_mem[r_rp];
  assign evtCHAN   = evtVALID ? w_head[DW-1 -: 4] : '0;
  assign evtLEVEL  = evtVALID ? w_head[TSWIDTH] : 1'b0;
  assign evtTIME   = evtVALID ? w_head[TSWIDTH-1:0] : '0;
  assign fifoCOUNT = r_count;
  assign dropCOUNT = r_drop;
  assign timeNOW   = r_time;

endmodule

// File: tb/tb_ks10_status_monitor.sv
// Scoreboard bench for ks10_status_monitor (3 channels, 4-bit time, depth 4, prescale 2).
module tb_ks10_status_monitor;

  logic       clk = 1'b0;
  logic       rst, clken, dropCLR, evtREADY;
  logic [2:0] statIN, evtMASK;
  logic       evtVALID, evtLEVEL;
  logic [3:0] evtCHAN, evtTIME, timeNOW;
  logic [2:0] fifoCOUNT;
  logic [7:0] dropCOUNT;

  ks10_status_monitor #(
    .CHANNELS(3), .TSWIDTH(4), .DEPTH(4), .PRESCALE(2)
  ) dut (
    .clk(clk), .rst(rst), .clken(clken), .statIN(statIN), .evtMASK(evtMASK),
    .dropCLR(dropCLR), .evtREADY(evtREADY), .evtVALID(evtVALID),
    .evtCHAN(evtCHAN), .evtLEVEL(evtLEVEL), .evtTIME(evtTIME),
    .fifoCOUNT(fifoCOUNT), .dropCOUNT(dropCOUNT), .timeNOW(timeNOW)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int lvl;
    int tm;
  } ev_t;

  ev_t q[$];
  int  n_pass = 0;
  int  n_total = 0;

  // Reference timebase: 4-bit tick counter advancing every second clken cycle
  logic [3:0] m_time;
  int         m_pc;
  always @(posedge clk) begin
    if (!rst) begin
      m_time <= 4'd0;
      m_pc   <= 0;
    end else if (clken) begin
      if (m_pc == 1) begin
        m_pc   <= 0;
        m_time <= m_time + 4'd1;
      end else begin
        m_pc <= m_pc + 1;
      end
    end
  end

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(int ch, int lvl);
    ev_t e;
    e.ch = ch; e.lvl = lvl; e.tm = int'(m_time);
    q.push_back(e);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_valid"}, int'(evtVALID), 0);
    chk({tag, "_chan"},  int'(evtCHAN), 0);
    chk({tag, "_level"}, int'(evtLEVEL), 0);
    chk({tag, "_time"},  int'(evtTIME), 0);
    chk({tag, "_count"}, int'(fifoCOUNT), 0);
    chk({tag, "_drop"},  int'(dropCOUNT), 0);
    chk({tag, "_now"},   int'(timeNOW), 0);
  endtask

  // Monitor: compares the head against the scoreboard on every handshake
  always @(negedge clk) begin
    if (rst && evtVALID && evtREADY) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got event ch=%0d lvl=%0d t=%0d, expected none",
                 evtCHAN, evtLEVEL, evtTIME);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_chan",  int'(evtCHAN), e.ch);
        chk("ev_level", int'(evtLEVEL), e.lvl);
        chk("ev_time",  int'(evtTIME), e.tm);
      end
    end
  end

  initial begin
    ev_t e;
    rst = 1'b0; clken = 1'b1; statIN = 3'b000; evtMASK = 3'b111;
    dropCLR = 1'b0; evtREADY = 1'b0;
    step(2);
    chk_reset("rst0");
    rst = 1'b1;

    // Single rise on ch0 at timestamp 3
    for (int k = 0; k < 100 && m_time != 4'd3; k++) step(1);
    statIN = 3'b001;
    expect_ev(0, 1);
    step(1);
    chk("rise_latency_valid", int'(evtVALID), 0);
    step(1);
    chk("rise_valid", int'(evtVALID), 1);
    chk("rise_count", int'(fifoCOUNT), 1);
    evtREADY = 1'b1;
    step(1);
    chk("rise_pop_valid", int'(evtVALID), 0);
    chk("rise_pop_count", int'(fifoCOUNT), 0);

    // Simultaneous edges on ch0 (fall), ch1, ch2 (rise)
    statIN = 3'b110;
    expect_ev(0, 0);
    expect_ev(1, 1);
    expect_ev(2, 1);
    step(2);
    chk("simul_streaming_valid", int'(evtVALID), 1);
    step(4);
    chk("simul_count", int'(fifoCOUNT), 0);
    chk("simul_sb_empty", q.size(), 0);

    // Backpressure: six ch1 toggles into a depth-4 FIFO
    evtREADY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      statIN[1] = ~statIN[1];
      if (i < 5) begin
        expect_ev(1, int'(statIN[1]));
      end else begin
        e = q.pop_back();
        e.lvl = int'(statIN[1]);
        q.push_back(e);
      end
      step(2);
    end
    chk("bp_count_full", int'(fifoCOUNT), 4);
    chk("bp_drop", int'(dropCOUNT), 1);
    chk("bp_head_valid", int'(evtVALID), 1);
    evtREADY = 1'b1;
    step(8);
    chk("bp_drained_count", int'(fifoCOUNT), 0);
    chk("bp_drained_valid", int'(evtVALID), 0);
    chk("bp_sb_empty", q.size(), 0);
    chk("bp_drop_held", int'(dropCOUNT), 1);
    dropCLR = 1'b1;
    step(1);
    dropCLR = 1'b0;
    chk("dropclr", int'(dropCOUNT), 0);

    // Timestamp wrap and clken freeze
    for (int k = 0; k < 10 && m_time == 4'd15; k++) step(1);
    for (int k = 0; k < 100 && m_time != 4'd15; k++) step(1);
    chk("wrap_15", int'(timeNOW), 15);
    step(1);
    chk("wrap_15_hold", int'(timeNOW), 15);
    step(1);
    chk("wrap_0", int'(timeNOW), 0);
    clken = 1'b0;
    step(5);
    chk("clken_freeze", int'(timeNOW), 0);
    clken = 1'b1;
    step(2);
    chk("clken_resume", int'(timeNOW), 1);

    // Masked ch0 toggles, then unmask while stable
    evtREADY = 1'b0;
    evtMASK = 3'b110;
    for (int i = 0; i < 4; i++) begin
      statIN[0] = ~statIN[0];
      step(1);
    end
    step(3);
    chk("mask_count", int'(fifoCOUNT), 0);
    chk("mask_valid", int'(evtVALID), 0);
    evtMASK = 3'b111;
    step(3);
    chk("unmask_count", int'(fifoCOUNT), 0);

    // Reset with three queued events and ch1 high
    statIN = 3'b010; expect_ev(2, 0); step(1);
    statIN = 3'b011; expect_ev(0, 1); step(1);
    statIN = 3'b010; expect_ev(0, 0); step(3);
    chk("pre_reset_count", int'(fifoCOUNT), 3);
    rst = 1'b0;
    step(1);
    chk_reset("midrst");
    q.delete();
    rst = 1'b1;
    expect_ev(1, 1);
    step(1);
    chk("post_rst_latency_valid", int'(evtVALID), 0);
    step(1);
    chk("post_rst_valid", int'(evtVALID), 1);
    chk("post_rst_count", int'(fifoCOUNT), 1);
    evtREADY = 1'b1;
    step(2);
    chk("post_rst_drained", int'(fifoCOUNT), 0);
    chk("final_sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
